// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared definitions for the bit-serial arithmetic primitives
//   (serial_sub today, serial_add later).
//   - sub_state_t : control state encoding (IDLE, SHIFT, DONE)
//   - cnt_width() : width of the bit counter for an operand width w
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // The counter must hold 0..w-1. Guard against w < 2 so the result
  // is never a zero-width vector.
  function automatic int cnt_width(input int w);
    if (w < 2) begin
      return 1;
    end
    return $clog2(w);
  endfunction

endpackage

// File: rtl/half_sub.sv
// half_sub
//   Combinational one-bit half subtractor computing a - b.
//   Ports:
//     a      : minuend bit
//     b      : subtrahend bit
//     diff   : a ^ b
//     borrow : 1 when a = 0 and b = 1
module half_sub (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_sub.sv
// serial_sub
//   Bit-serial subtractor: diff = a - b (mod 2^W), LSB first, one bit
//   per clock. Operands arrive on a valid/ready handshake; the result
//   leaves on a valid/ready handshake and is held until accepted.
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     in_valid / in_ready  : operand handshake (a = minuend, b = subtrahend)
//     out_valid / out_ready: result handshake
//     diff                 : a - b modulo 2^W
//     borrow_out           : final borrow, 1 when a < b unsigned
//     ovf                  : two's-complement overflow of a - b
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow_out,
  output logic         ovf
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  sub_state_t    state_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  diff_reg;
  logic [CW-1:0] count_reg;
  logic          borrow_reg;
  logic          sa_reg;
  logic          sb_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          borrow_out_reg;
  logic          ovf_reg;

  // Full subtract of the current LSBs built from two half subtractors.
  logic d1;
  logic b1;
  logic d;
  logic b2;
  logic borrow_next;

  half_sub u_hs_ab (
    .a      (a_reg[0]),
    .b      (b_reg[0]),
    .diff   (d1),
    .borrow (b1)
  );

  half_sub u_hs_borrow (
    .a      (d1),
    .b      (borrow_reg),
    .diff   (d),
    .borrow (b2)
  );

  assign borrow_next = b1 | b2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      diff_reg       <= '0;
      count_reg      <= '0;
      borrow_reg     <= 1'b0;
      sa_reg         <= 1'b0;
      sb_reg         <= 1'b0;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      borrow_out_reg <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_reg        <= a;
            b_reg        <= b;
            borrow_reg   <= 1'b0;
            count_reg    <= '0;
            sa_reg       <= a[W-1];
            sb_reg       <= b[W-1];
            in_ready_reg <= 1'b0;
            state_reg    <= SHIFT;
          end
        end

        SHIFT: begin
          // Result bits enter at the MSB so after W shifts bit 0 sits at diff[0].
          diff_reg   <= {d, diff_reg[W-1:1]};
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          borrow_reg <= borrow_next;
          count_reg  <= count_reg + CW'(1);
          if (count_reg == LAST) begin
            state_reg      <= DONE;
            out_valid_reg  <= 1'b1;
            borrow_out_reg <= borrow_next;
            // d is the result MSB being shifted in on this edge.
            ovf_reg        <= (sa_reg != sb_reg) && (d != sa_reg);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign diff       = diff_reg;
  assign borrow_out = borrow_out_reg;
  assign ovf        = ovf_reg;

endmodule
